// File: rtl/clock_ui_ctrl.sv
// Front-panel UI controller for the digital clock: button presses -> mode FSM, cfg registers, strobes, buzzer arbitration.
// Latency: press acts at the first posedge it is seen (+2 posedges with CLK_UI_SYNC_EN defined); ring pulses act at the sampling posedge.
// Backpressure: none; buttons are levels, ring inputs are single-cycle pulses, strobes are fire-and-forget one-cycle pulses.
module clock_ui_ctrl #(
  parameter int RING_CYCLES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       add_hour,
  input  logic       add_minute,
  input  logic       set_timer_btn,
  input  logic       set_alarm_btn,
  input  logic       timer_done,
  input  logic       alarm_match,
  output logic [1:0] state,
  output logic [5:0] timer_min_cfg,
  output logic       timer_load,
  output logic [4:0] alarm_hr_cfg,
  output logic [5:0] alarm_min_cfg,
  output logic       alarm_load,
  output logic       time_inc_hr,
  output logic       time_inc_min,
  output logic       buzzer_out,
  output logic [1:0] buzzer_src
);

  typedef enum logic [1:0] {
    CLOCK     = 2'd0,
    TIMER_SET = 2'd1,
    ALARM_SET = 2'd2,
    TIME_SET  = 2'd3
  } mode_t;

  localparam int CW = (RING_CYCLES < 2) ? 1 : $clog2(RING_CYCLES + 1);

  // Button vector bit order: 4 mode, 3 set_timer, 2 set_alarm, 1 add_hour, 0 add_minute
  logic [4:0] btn_raw;
  logic [4:0] btn;
  logic [4:0] btn_prev;
  logic [4:0] press;

  assign btn_raw = {mode_btn, set_timer_btn, set_alarm_btn, add_hour, add_minute};

`ifdef CLK_UI_SYNC_EN
  logic [4:0] btn_sync1;
  logic [4:0] btn_sync2;

  // Two-flop synchronizer on the asynchronous front-panel buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_sync1 <= '0;
      btn_sync2 <= '0;
    end else begin
      btn_sync1 <= btn_raw;
      btn_sync2 <= btn_sync1;
    end
  end

  assign btn = btn_sync2;
`else
  assign btn = btn_raw;
`endif

  // Previous button levels for rising-edge (press) detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_prev <= '0;
    else        btn_prev <= btn;
  end

  assign press = btn & ~btn_prev;

  mode_t         st;
  logic          timer_ringing;
  logic          alarm_ringing;
  logic [CW-1:0] ring_cnt;
  logic          ringing;
  logic          silence;
  logic          ring_evt;
  logic          expire;
  logic          ring_clr;

  assign ringing  = timer_ringing | alarm_ringing;
  assign silence  = press[4] & ringing;
  assign ring_evt = timer_done | alarm_match;
  assign expire   = ringing & (ring_cnt <= CW'(1));
  // A fresh ring event restarts the count, so expiry only clears when nothing new arrives
  assign ring_clr = silence | (expire & ~ring_evt);

  assign state      = st;
  assign buzzer_src = {alarm_ringing, timer_ringing};
  assign buzzer_out = ringing;

  // Mode FSM: one prioritized press per cycle drives state, cfg registers and strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= CLOCK;
      timer_min_cfg <= '0;
      alarm_hr_cfg  <= '0;
      alarm_min_cfg <= '0;
      timer_load    <= 1'b0;
      alarm_load    <= 1'b0;
      time_inc_hr   <= 1'b0;
      time_inc_min  <= 1'b0;
    end else begin
      timer_load   <= 1'b0;
      alarm_load   <= 1'b0;
      time_inc_hr  <= 1'b0;
      time_inc_min <= 1'b0;
      // Timer cfg is held through the load strobe cycle, then cleared
      if (timer_load) timer_min_cfg <= '0;

      if (press[4]) begin
        // A mode press while ringing only silences the buzzer
        if (!ringing) st <= mode_t'(st + 2'd1);
      end else if (press[3] | press[2]) begin
        if (st == TIMER_SET && press[3]) begin
          timer_load <= 1'b1;
          st         <= CLOCK;
        end else if (st == ALARM_SET && press[2]) begin
          alarm_load <= 1'b1;
          st         <= CLOCK;
        end
      end else if (press[1]) begin
        case (st)
          ALARM_SET: alarm_hr_cfg <= (alarm_hr_cfg == 5'd23) ? 5'd0 : alarm_hr_cfg + 5'd1;
          TIME_SET:  time_inc_hr  <= 1'b1;
          default:   ;
        endcase
      end else if (press[0]) begin
        case (st)
          TIMER_SET: timer_min_cfg <= (timer_min_cfg == 6'd59) ? 6'd0 : timer_min_cfg + 6'd1;
          ALARM_SET: alarm_min_cfg <= (alarm_min_cfg == 6'd59) ? 6'd0 : alarm_min_cfg + 6'd1;
          TIME_SET:  time_inc_min  <= 1'b1;
          default:   ;
        endcase
      end
    end
  end

  // Buzzer arbitration: ring flags plus auto-timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_ringing <= 1'b0;
      alarm_ringing <= 1'b0;
      ring_cnt      <= '0;
    end else begin
      timer_ringing <= timer_done  | (timer_ringing & ~ring_clr);
      alarm_ringing <= alarm_match | (alarm_ringing & ~ring_clr);
      if (ring_evt)      ring_cnt <= CW'(RING_CYCLES);
      else if (ring_clr) ring_cnt <= '0;
      else if (ringing)  ring_cnt <= ring_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_clock_ui_ctrl.sv
// Self-checking bench for clock_ui_ctrl (default build, CLK_UI_SYNC_EN undefined).
// Table-driven timer-set vectors, hand-written multi-cycle corner cases, then random
// stimulus compared every cycle against a behavioural model.
module tb_clock_ui_ctrl;
  localparam int RING = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0, add_hour = 1'b0, add_minute = 1'b0;
  logic       set_timer_btn = 1'b0, set_alarm_btn = 1'b0;
  logic       timer_done = 1'b0, alarm_match = 1'b0;
  logic [1:0] state;
  logic [5:0] timer_min_cfg;
  logic       timer_load;
  logic [4:0] alarm_hr_cfg;
  logic [5:0] alarm_min_cfg;
  logic       alarm_load, time_inc_hr, time_inc_min, buzzer_out;
  logic [1:0] buzzer_src;

  clock_ui_ctrl #(.RING_CYCLES(RING)) dut (
    .clk(clk), .reset(reset),
    .mode_btn(mode_btn), .add_hour(add_hour), .add_minute(add_minute),
    .set_timer_btn(set_timer_btn), .set_alarm_btn(set_alarm_btn),
    .timer_done(timer_done), .alarm_match(alarm_match),
    .state(state), .timer_min_cfg(timer_min_cfg), .timer_load(timer_load),
    .alarm_hr_cfg(alarm_hr_cfg), .alarm_min_cfg(alarm_min_cfg), .alarm_load(alarm_load),
    .time_inc_hr(time_inc_hr), .time_inc_min(time_inc_min),
    .buzzer_out(buzzer_out), .buzzer_src(buzzer_src)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] B_MODE = 5'b10000, B_SETT = 5'b01000, B_SETA = 5'b00100,
                         B_HR   = 5'b00010, B_MIN  = 5'b00001, B_NONE = 5'b00000;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // One clock: drive at negedge, sample 1 time unit after posedge
  task automatic cyc(input logic [4:0] b, input logic td, input logic am);
    @(negedge clk);
    {mode_btn, set_timer_btn, set_alarm_btn, add_hour, add_minute} = b;
    timer_done  = td;
    alarm_match = am;
    @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic [4:0] b);
    cyc(b, 1'b0, 1'b0);
    cyc(B_NONE, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {mode_btn, set_timer_btn, set_alarm_btn, add_hour, add_minute} = '0;
    timer_done = 1'b0;
    alarm_match = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] dut_vec();
    return {6'd0, state, timer_min_cfg, timer_load, alarm_hr_cfg, alarm_min_cfg,
            alarm_load, time_inc_hr, time_inc_min, buzzer_out, buzzer_src};
  endfunction

  // ---------------- behavioural reference model ----------------
  int       m_state, m_tcfg, m_ahr, m_amin, m_left;
  bit       m_tl, m_al, m_ih, m_im, m_tr, m_ar;
  bit [4:0] m_prev;

  task automatic model_reset();
    m_state = 0; m_tcfg = 0; m_ahr = 0; m_amin = 0; m_left = 0;
    m_tl = 0; m_al = 0; m_ih = 0; m_im = 0; m_tr = 0; m_ar = 0; m_prev = '0;
  endtask

  task automatic model_step(input bit [4:0] b, input bit td, input bit am);
    bit [4:0] p;
    bit buzz, sil;
    p = b & ~m_prev;
    m_prev = b;
    buzz = m_tr | m_ar;
    sil = p[4] & buzz;
    if (m_tl) m_tcfg = 0;
    m_tl = 0; m_al = 0; m_ih = 0; m_im = 0;
    if (p[4]) begin
      if (!buzz) m_state = (m_state + 1) % 4;
    end else if (p[3] || p[2]) begin
      if (m_state == 1 && p[3]) begin m_tl = 1; m_state = 0; end
      else if (m_state == 2 && p[2]) begin m_al = 1; m_state = 0; end
    end else if (p[1]) begin
      if (m_state == 2) m_ahr = (m_ahr + 1) % 24;
      else if (m_state == 3) m_ih = 1;
    end else if (p[0]) begin
      if (m_state == 1) m_tcfg = (m_tcfg + 1) % 60;
      else if (m_state == 2) m_amin = (m_amin + 1) % 60;
      else if (m_state == 3) m_im = 1;
    end
    if (td || am) begin
      if (sil) begin m_tr = 0; m_ar = 0; end
      m_tr = m_tr | td;
      m_ar = m_ar | am;
      m_left = RING;
    end else if (sil) begin
      m_tr = 0; m_ar = 0; m_left = 0;
    end else if (buzz) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_tr = 0; m_ar = 0; end
    end
  endtask

  function automatic logic [31:0] model_vec();
    return {6'd0, 2'(m_state), 6'(m_tcfg), m_tl, 5'(m_ahr), 6'(m_amin),
            m_al, m_ih, m_im, (m_tr | m_ar), {m_ar, m_tr}};
  endfunction

  typedef struct {
    logic [4:0] btn;
    logic [1:0] st;
    logic [5:0] tcfg;
    logic       tl;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [4:0] rb;
    logic       rtd, ram;
    int         hi, badsrc, loads;

    // Vector table: mode, 5x add_minute, set_timer
    vecs.push_back('{B_NONE, 2'd0, 6'd0, 1'b0});
    vecs.push_back('{B_MODE, 2'd1, 6'd0, 1'b0});
    vecs.push_back('{B_NONE, 2'd1, 6'd0, 1'b0});
    for (int k = 1; k <= 5; k++) begin
      vecs.push_back('{B_MIN,  2'd1, 6'(k), 1'b0});
      vecs.push_back('{B_NONE, 2'd1, 6'(k), 1'b0});
    end
    vecs.push_back('{B_SETT, 2'd0, 6'd5, 1'b1});
    vecs.push_back('{B_NONE, 2'd0, 6'd0, 1'b0});
    vecs.push_back('{B_NONE, 2'd0, 6'd0, 1'b0});

    #3;
    check("reset_outputs", dut_vec(), 32'd0);
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].btn, 1'b0, 1'b0);
      check($sformatf("vec%0d", i), {23'd0, state, timer_min_cfg, timer_load},
            {23'd0, vecs[i].st, vecs[i].tcfg, vecs[i].tl});
    end

    // Alarm set with hour/minute wrap
    tap(B_MODE);
    tap(B_MODE);
    check("alarm_enter_state", {30'd0, state}, 32'd2);
    loads = 0;
    for (int k = 0; k < 25; k++) begin tap(B_HR); loads += alarm_load; end
    for (int k = 0; k < 61; k++) begin tap(B_MIN); loads += alarm_load; end
    cyc(B_SETA, 1'b0, 1'b0);
    check("alarm_load_pulse", {16'd0, alarm_load, state, alarm_hr_cfg, alarm_min_cfg, 2'd0},
          {16'd0, 1'b1, 2'd0, 5'd1, 6'd1, 2'd0});
    loads += alarm_load;
    cyc(B_NONE, 1'b0, 1'b0);
    loads += alarm_load;
    check("alarm_cfg_retained", {20'd0, alarm_load, alarm_hr_cfg, alarm_min_cfg},
          {20'd0, 1'b0, 5'd1, 6'd1});
    check("alarm_load_count", 32'(loads), 32'd1);

    // Simultaneous mode + add_minute in TIMER_SET: mode wins
    tap(B_MODE);
    tap(B_MIN);
    cyc(B_MODE | B_MIN, 1'b0, 1'b0);
    check("prio_mode_over_min", {24'd0, state, timer_min_cfg}, {24'd0, 2'd2, 6'd1});
    cyc(B_NONE, 1'b0, 1'b0);
    tap(B_MODE);
    tap(B_MODE);
    check("back_to_clock", {30'd0, state}, 32'd0);

    // Timer ring with auto-timeout
    cyc(B_NONE, 1'b1, 1'b0);
    hi = 0;
    badsrc = 0;
    for (int k = 0; k < 100; k++) begin
      if (buzzer_out) begin
        hi++;
        if (buzzer_src !== 2'b01) badsrc++;
      end
      cyc(B_NONE, 1'b0, 1'b0);
    end
    check("ring_duration", 32'(hi), 32'(RING));
    check("ring_src_timer", 32'(badsrc), 32'd0);
    check("ring_off_after", {31'd0, buzzer_out}, 32'd0);

    // Silence in TIME_SET, then alarm_match coincident with silence press
    tap(B_MODE); tap(B_MODE); tap(B_MODE);
    cyc(B_NONE, 1'b1, 1'b0);
    repeat (3) cyc(B_NONE, 1'b0, 1'b0);
    cyc(B_MODE, 1'b0, 1'b0);
    check("silence", {29'd0, buzzer_out, state}, {29'd0, 1'b0, 2'd3});
    cyc(B_NONE, 1'b0, 1'b0);
    cyc(B_NONE, 1'b1, 1'b0);
    cyc(B_NONE, 1'b0, 1'b0);
    cyc(B_MODE, 1'b0, 1'b1);
    check("ring_beats_silence", {27'd0, buzzer_out, buzzer_src, state},
          {27'd0, 1'b1, 2'b10, 2'd3});

    // Reset asserted during timer_load, add_hour held across release
    do_reset();
    tap(B_MODE);
    for (int k = 0; k < 7; k++) tap(B_MIN);
    cyc(B_SETT, 1'b0, 1'b0);
    check("tload_before_reset", {25'd0, timer_load, timer_min_cfg}, {25'd0, 1'b1, 6'd7});
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", dut_vec(), 32'd0);
    add_hour = 1'b1;
    set_timer_btn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("held_hr_after_reset", {29'd0, time_inc_hr, state}, 32'd0);
    cyc(B_HR, 1'b0, 1'b0);
    cyc(B_HR, 1'b0, 1'b0);
    check("held_hr_no_pulse", {29'd0, time_inc_hr, state}, 32'd0);

    // Random stimulus against the reference model
    do_reset();
    model_reset();
    rb = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < 5; j++)
        if ($urandom_range(0, 3) == 0) rb[j] = ~rb[j];
      rtd = ($urandom_range(0, 49) == 0);
      ram = ($urandom_range(0, 49) == 0);
      cyc(rb, rtd, ram);
      model_step(rb, rtd, ram);
      check($sformatf("model_cyc%0d", n), dut_vec(), model_vec());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
